// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encodings and
// the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DRAIN = 2'd2,
    SA_DONE  = 2'd3
  } sa_state_e;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int sa_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl.sv
// Bit-serial sequencer feeding a registered 1-bit full adder, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             result_ovf
`endif
);

  localparam int CNT_W = sa_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             cmsb_q, cmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state, datapath capture and handshake/adder drive decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cin_d     = cin_q;
    res_d     = res_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d    = cmsb_q;
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;

    case (state_q)
      SA_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          cin_d   = op_cin;
          cnt_d   = '0;
          state_d = SA_SHIFT;
        end else begin
          state_d = SA_IDLE;
        end
      end
      SA_SHIFT: begin
        fa_a   = a_sh_q[0];
        fa_b   = b_sh_q[0];
        // Adder output is unreset until bit 0 has been clocked through it.
        fa_cin = (cnt_q == '0) ? cin_q : fa_cout;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q != '0) begin
          res_d = {fa_sum, res_q[WIDTH-1:1]};
        end else begin
          res_d = res_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = SA_DRAIN;
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d  = fa_cout;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      SA_DRAIN: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = cmsb_q ^ fa_cout;
`endif
        state_d = SA_DONE;
      end
      SA_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = SA_IDLE;
        end else begin
          state_d = SA_DONE;
        end
      end
      default: begin
        state_d = SA_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SA_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign result      = res_q;
  assign result_cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign result_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=4) with a behavioural
// registered full adder standing in for full_adder_1bit.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             result_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .fa_a        (fa_a),
    .fa_b        (fa_b),
    .fa_cin      (fa_cin),
    .fa_sum      (fa_sum),
    .fa_cout     (fa_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .result_ovf  (result_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered full adder without reset.
  always @(posedge clk) begin
    {fa_cout, fa_sum} <= 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one operation starting just after a negedge; ends just after a negedge in IDLE.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic [3:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    int k;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".rdy_shift"}, 32'(in_ready), 32'd0);
    chk({tag, ".fa_a0"}, 32'(fa_a), 32'(a[0]));
    chk({tag, ".fa_cin0"}, 32'(fa_cin), 32'(cin));
    k = 0;
    while (k < 20) begin
      k++;
      @(posedge clk);
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, ".latency"}, 32'(k), 32'd5);
    chk({tag, ".result"}, 32'(result), 32'(exp_res));
    chk({tag, ".cout"}, 32'(result_cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, 32'(result_ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk({tag, ".ovf_x"}, 32'(exp_ovf), 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op_a      = 4'hA;
    op_b      = 4'hA;
    op_cin    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.cout", 32'(result_cout), 32'd0);
    chk("rst.fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst.ovf", 32'(result_ovf), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("rst_vs_valid", 32'(in_ready), 32'd1);

    run_op("t1", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1);
    run_op("t2", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run_op("t3", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    run_op("t4", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

    // Hold in DONE with new operands pending.
    op_a = 4'h1; op_b = 4'h1; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 4'h9; op_b = 4'h9;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t5.hold_vld", 32'(out_valid), 32'd1);
      chk("t5.hold_res", 32'(result), 32'h2);
      chk("t5.hold_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5.idle_rdy", 32'(in_ready), 32'd1);
    chk("t5.idle_res", 32'(result), 32'h2);
    run_op("t5b", 4'h9, 4'h9, 1'b0, 4'h2, 1'b1, 1'b1);

    // Reset during SHIFT bit 2.
    op_a = 4'hA; op_b = 4'h3; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t6.rdy", 32'(in_ready), 32'd1);
    chk("t6.res", 32'(result), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("t6.no_pulse", 32'(pulses), 32'd0);
    run_op("t6b", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
